// File: rtl/des_pkg.sv
// Shared types and the IP-inverse bit mapping for the DES datapath.
// Used by the RTL and by the bench model.
package des_pkg;

  localparam int DES_BLOCK_W = 64;

  typedef logic [31:0] des_half_t;
  typedef logic [DES_BLOCK_W-1:0] des_block_t;

  // Output bit n takes bit 31-8g-j of L (odd n) or R (even n),
  // where g = (n mod 8) div 2 and j = 7 - (n div 8).
  function automatic des_block_t des_ip_inv_f(
    input des_half_t l,
    input des_half_t r
  );
    des_block_t b;
    int g;
    int j;
    int k;
    b = '0;
    for (int n = 0; n < DES_BLOCK_W; n++) begin
      g = (n % 8) / 2;
      j = 7 - (n / 8);
      k = 31 - 8 * g - j;
      b[n] = n[0] ? l[k[4:0]] : r[k[4:0]];
    end
    return b;
  endfunction

endpackage

// File: rtl/des_ip_inv_if.sv
// Input halves and output block handshake of the IP-inverse stage.
// slave = stage side, master = producer/consumer side.
interface des_ip_inv_if #(
  parameter int DEPTH = 2
);
  import des_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  des_half_t  left_data_in;
  des_half_t  right_data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  des_block_t data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [LW-1:0] fifo_level;
  logic [15:0]   block_cnt;

  modport slave (
    input  left_data_in,
    input  right_data_in,
    input  data_in_valid,
    output data_in_ready,
    output data_out,
    output data_out_valid,
    input  data_out_ready,
    output fifo_level,
    output block_cnt
  );

  modport master (
    output left_data_in,
    output right_data_in,
    output data_in_valid,
    input  data_in_ready,
    input  data_out,
    input  data_out_valid,
    output data_out_ready,
    input  fifo_level,
    input  block_cnt
  );

endinterface

// File: rtl/des_buf.sv
// Generic synchronous FIFO; head word reads as zero when empty.
// Storage is not reset, only pointers and level.
module des_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [W-1:0]               wdata_in,
  output logic [W-1:0]               rdata_out,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       full_out,
  output logic                       empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_out  = (level_q == LW'(DEPTH));
  assign empty_out = (level_q == '0);
  assign push_ok   = push_in && !full_out;
  assign pop_ok    = pop_in && !empty_out;
  assign level_out = level_q;
  assign rdata_out = empty_out ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy from the accepted push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write, no reset needed
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_in;
  end

endmodule

// File: rtl/des_ip_inv.sv
// DES IP-inverse tail stage: permute halves, buffer 64-bit blocks.
// DES_IP_INV_SWAP_EN: exchange L/R before permuting (R16||L16 swap).
module des_ip_inv
  import des_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  des_ip_inv_if.slave bus
);

  des_half_t  l_sel;
  des_half_t  r_sel;
  des_block_t perm;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [15:0] cnt_q, cnt_d;

`ifdef DES_IP_INV_SWAP_EN
  assign l_sel = bus.right_data_in;
  assign r_sel = bus.left_data_in;
`else
  assign l_sel = bus.left_data_in;
  assign r_sel = bus.right_data_in;
`endif

  assign perm = des_ip_inv_f(l_sel, r_sel);

  assign bus.data_in_ready  = !full;
  assign bus.data_out_valid = !empty;
  assign push = bus.data_in_valid && !full;
  assign pop  = bus.data_out_ready && !empty;

  des_buf #(
    .DEPTH (DEPTH),
    .W     (DES_BLOCK_W)
  ) u_buf (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (push),
    .pop_in    (pop),
    .wdata_in  (perm),
    .rdata_out (bus.data_out),
    .level_out (bus.fifo_level),
    .full_out  (full),
    .empty_out (empty)
  );

  // Delivered-block counter, wraps at 16 bits
  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign bus.block_cnt = cnt_q;

endmodule

// File: doc/des_ip_inv.md
# des_ip_inv

Inverse initial permutation (IP⁻¹) stage for the DES datapath. It accepts the 32-bit left and right halves leaving the round pipeline and reassembles them into a 64-bit block using the exact inverse of the team's initial-permutation bit mapping. The result is buffered in a small FIFO so the output consumer can apply backpressure. The block sits at the tail of the cipher core, mirroring the initial-permutation stage at its head.

## Interface
- DEPTH, 2, output FIFO entries; power of two, at least 2.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- left_data_in  input  32  left half from the round pipeline.
- right_data_in  input  32  right half from the round pipeline.
- data_in_valid  input  1  halves are valid this cycle.
- data_in_ready  output  1  block can accept this cycle.
- data_out  output  64  reassembled block at the FIFO head.
- data_out_valid  output  1  data_out holds a valid block.
- data_out_ready  input  1  consumer accepts data_out this cycle.
- fifo_level  output  $clog2(DEPTH)+1  number of occupied entries.
- block_cnt  output  16  count of blocks delivered on the output; wraps.

## Operation
- Push occurs when data_in_valid && data_in_ready. Pop occurs when data_out_valid && data_out_ready.
- Permutation is applied on push; the FIFO stores permuted 64-bit words.
- Mapping, for n = 0..63, with bit 0 = LSB:
  - g = (n mod 8) div 2 and j = 7 − (n div 8).
  - data_out[n] = L[31−8g−j] when n is odd.
  - data_out[n] = R[31−8g−j] when n is even.
  - Examples: data_out[7] = L[0], data_out[6] = R[0], data_out[57] = L[31], data_out[56] = R[31].
- L and R are left_data_in and right_data_in, unless exchanged by the configuration option below.
- Round trip: feeding this block the halves produced by the team's initial-permutation stage reproduces that stage's original 64-bit input.
- data_in_ready = (fifo_level != DEPTH). It depends only on registered state; there is no combinational path from data_out_ready.
- data_out_valid = (fifo_level != 0). data_out shows the head entry and is stable while data_out_valid && !data_out_ready.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- fifo_level update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- block_cnt increments by 1 on each pop and wraps from 16'hFFFF to 0.
- When empty, only push is possible. When full, only pop is possible, because data_in_ready is low.
- Simultaneous push and pop are legal whenever fifo_level is between 1 and DEPTH−1.

## Timing
- Reset values, effective asynchronously on rst_n_in low: pointers = 0, fifo_level = 0, data_out_valid = 0, data_in_ready = 1, data_out = 64'h0, block_cnt = 0.
- FIFO storage is not reset. data_out is forced to 0 while the FIFO is empty.
- Latency: a block pushed at edge N is visible on data_out with data_out_valid = 1 after edge N if the FIFO was empty. Otherwise it appears after all earlier entries have been popped.
- Throughput: one block per cycle when data_out_ready is held high.
- Reset mid-operation discards all entries. data_in_ready returns high on the first cycle with rst_n_in deasserted.
- data_in_valid asserted while data_in_ready is low: the block is not taken and no state changes. The sender must hold the data.

## Configuration
- Macro: DES_IP_INV_SWAP_EN.
- When defined, the halves are exchanged before permutation (L = right_data_in, R = left_data_in). This implements the DES R16‖L16 pre-output swap inside this block.
- When undefined, no swap is performed; the swap is done upstream in the round pipeline.
- The macro has no effect on interface or timing.

## Structure
- Package des_pkg holds:
  - a des_half_t typedef (32-bit) and a des_block_t typedef (64-bit);
  - the constant DES_BLOCK_W = 64;
  - the function des_ip_inv_f(L, R), which returns des_block_t and is shared with the bench model.
- Sub-module des_buf: a generic synchronous FIFO (DEPTH, width 64) that provides level, push/pop and head output.
- des_ip_inv instantiates des_buf and contains the permutation, the optional swap and block_cnt.

## Test plan
- Single bits, swap disabled: L = 32'h1, R = 0 → data_out = 64'h80. L = 0, R = 32'h1 → 64'h40. L = 32'h8000_0000, R = 0 → 64'h0200_0000_0000_0000. L = 0, R = 32'h8000_0000 → 64'h0100_0000_0000_0000. Each appears one cycle after the push.
- Swap enabled: L = 32'h1, R = 0 → data_out = 64'h40. All-ones halves → 64'hFFFF_FFFF_FFFF_FFFF in both configurations.
- Backpressure: hold data_out_ready = 0 and push 3 blocks with DEPTH = 2. Only 2 are accepted, data_in_ready goes low after the second, and fifo_level = 2. Then release data_out_ready: blocks pop in order, and block_cnt = 2.
- Streaming: 1000 random blocks with random valid/ready. Every output equals des_ip_inv_f of its input, in order. The round trip through the initial-permutation stage model returns the original 64-bit words.
- Wrap: 65537 pops → block_cnt = 1.
- Reset mid-stream: assert rst_n_in with fifo_level = 1. Outputs are immediately at their reset values, and the discarded block never appears on data_out.
